// File: rtl/retospect_bs_loader.sv
// retospect_bs_loader: host-side writer for the neurochip configuration shift chain.
// Accepts config bytes on a valid/ready stream and serialises them LSB-first onto
// bs_out, holding config_en high for exactly CHAIN_LEN shift cycles per load.
// Optional readback of the chain's previous contents: define RETOSPECT_BS_READBACK_EN.
module retospect_bs_loader #(
    parameter int unsigned CHAIN_LEN = 523,
    parameter int unsigned CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       config_en,
    output logic       bs_out,
    input  logic       bs_ret,
    output logic       busy,
    output logic       done,
    output logic [7:0] rb_data,
    output logic       rb_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       byte_bit;
    logic [7:0]       sr;
    logic             last_bit;
    logic             byte_end;

    // Current SHIFT cycle emits the final chain bit / the last bit of a byte with more to come.
    assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign byte_end = (byte_bit == 3'd7) && !last_bit;

    // Handshake is combinational so a held byte can be taken with no shift gap.
    assign din_ready = (state == ST_WAIT) || ((state == ST_SHIFT) && byte_end);

    // Load sequencer: state, counters, shift register and registered chain outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_bit  <= '0;
            sr        <= '0;
            config_en <= 1'b0;
            bs_out    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            config_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_WAIT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (din_valid) begin
                        sr       <= din;
                        byte_bit <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    config_en <= 1'b1;
                    bs_out    <= sr[0];
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    byte_bit  <= byte_bit + 3'd1;
                    if (last_bit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (byte_end) begin
                        if (din_valid) begin
                            sr <= din;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        sr <= {1'b0, sr[7:1]};
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RETOSPECT_BS_READBACK_EN
    localparam int unsigned REM   = CHAIN_LEN % 8;
    localparam int unsigned RB_SH = (REM == 0) ? 0 : (8 - REM);

    logic [7:0] rb_sr;
    logic [2:0] rb_cnt;
    logic [7:0] rb_next;

    assign rb_next = {bs_ret, rb_sr[7:1]};

    // Capture the old tail bit on every chain shift; the last shift of a load lands in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_sr    <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                rb_cnt <= '0;
            end else if (config_en) begin
                rb_sr  <= rb_next;
                rb_cnt <= rb_cnt + 3'd1;
                if (state == ST_DONE) begin
                    rb_valid <= 1'b1;
                    rb_data  <= rb_next >> RB_SH;
                end else if (rb_cnt == 3'd7) begin
                    rb_valid <= 1'b1;
                    rb_data  <= rb_next;
                end
            end
        end
    end
`else
    logic rb_unused;
    assign rb_unused = bs_ret;
    assign rb_data   = '0;
    assign rb_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Self-checking bench for retospect_bs_loader: three instances (11, 16 and 523 chain bits)
// with a behavioural chain model on each, driven from per-scenario tasks.
module tb_retospect_bs_loader;

    localparam int MAXL = 523;
    localparam int MAXB = 66;

`ifdef RETOSPECT_BS_READBACK_EN
    localparam int RB_ON = 1;
`else
    localparam int RB_ON = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start_v [3];
    logic [7:0] din_v   [3];
    logic       dval    [3];
    logic       rdy     [3];
    logic       cen     [3];
    logic       bso     [3];
    logic       bsr     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] rbd     [3];
    logic       rbv     [3];

    int tests = 0;
    int fails = 0;

    // Chain model (index 0 = tail) and observation counters per instance.
    bit         chain    [3][MAXL];
    bit         obs      [3][MAXL];
    int         hi_n     [3];
    int         low_run  [3];
    int         gaps_sum [3];
    int         rdy_n    [3];
    int         done_n   [3];
    int         rb_n     [3];
    logic [7:0] rb_got   [3][MAXB];
    bit         prev_cen [3];
    bit         prev_bso [3];

    logic [7:0] host [3][MAXB];
    int         gapv [3][MAXB];

    retospect_bs_loader #(.CHAIN_LEN(11), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .din(din_v[0]), .din_valid(dval[0]),
        .din_ready(rdy[0]), .config_en(cen[0]), .bs_out(bso[0]), .bs_ret(bsr[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rb_data(rbd[0]), .rb_valid(rbv[0]));

    retospect_bs_loader #(.CHAIN_LEN(16), .CNT_W(5)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .din(din_v[1]), .din_valid(dval[1]),
        .din_ready(rdy[1]), .config_en(cen[1]), .bs_out(bso[1]), .bs_ret(bsr[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rb_data(rbd[1]), .rb_valid(rbv[1]));

    retospect_bs_loader #(.CHAIN_LEN(523), .CNT_W(10)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .din(din_v[2]), .din_valid(dval[2]),
        .din_ready(rdy[2]), .config_en(cen[2]), .bs_out(bso[2]), .bs_ret(bsr[2]),
        .busy(busy_v[2]), .done(done_v[2]), .rb_data(rbd[2]), .rb_valid(rbv[2]));

    assign bsr[0] = chain[0][0];
    assign bsr[1] = chain[1][0];
    assign bsr[2] = chain[2][0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int len_of(input int d);
        if (d == 0) return 11;
        if (d == 1) return 16;
        return 523;
    endfunction

    function automatic logic [7:0] last_mask(input int d);
        int r;
        logic [7:0] m;
        r = len_of(d) % 8;
        m = 8'hFF;
        if (r != 0) m = m >> (8 - r);
        return m;
    endfunction

    // Chain behaviour: apply the shift of the edge that just passed, then sample outputs.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int L;
            L = len_of(d);
            if (prev_cen[d]) begin
                for (int i = 0; i < L - 1; i++) chain[d][i] = chain[d][i+1];
                chain[d][L-1] = prev_bso[d];
            end
            if (cen[d] === 1'b1) begin
                if (hi_n[d] > 0) gaps_sum[d] += low_run[d];
                low_run[d] = 0;
                if (hi_n[d] < MAXL) obs[d][hi_n[d]] = bso[d];
                hi_n[d]++;
            end else if (hi_n[d] > 0) begin
                low_run[d]++;
            end
            if (rdy[d] === 1'b1) rdy_n[d]++;
            if (done_v[d] === 1'b1) done_n[d]++;
            if (rbv[d] === 1'b1) begin
                if (rb_n[d] < MAXB) rb_got[d][rb_n[d]] = rbd[d];
                rb_n[d]++;
            end
            prev_cen[d] = (cen[d] === 1'b1);
            prev_bso[d] = (bso[d] === 1'b1);
        end
    end

    task automatic clear_mon(input int d);
        hi_n[d] = 0; low_run[d] = 0; gaps_sum[d] = 0;
        rdy_n[d] = 0; done_n[d] = 0; rb_n[d] = 0;
    endtask

    // Host driver: start, then feed host[d] bytes honouring gapv[d] delays after din_ready.
    task automatic run_load(input int d, input bit poke);
        int L, nb, n;
        L  = len_of(d);
        nb = (L + 7) / 8;
        clear_mon(d);
        @(negedge clk); start_v[d] = 1'b1;
        @(negedge clk); start_v[d] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (k > 0 && gapv[d][k] > 0) begin
                dval[d] = 1'b0;
                n = 0;
                while (rdy[d] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
                repeat (gapv[d][k]) @(negedge clk);
            end
            din_v[d] = host[d][k];
            dval[d]  = 1'b1;
            n = 0;
            while (rdy[d] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
            tests++;
            if (rdy[d] !== 1'b1) begin
                fails++;
                $display("FAIL ready_timeout dut%0d byte %0d: din_ready=%b, required 1", d, k, rdy[d]);
            end
            @(negedge clk);
            if (poke && k == 0) begin
                start_v[d] = 1'b1;
                @(negedge clk);
                start_v[d] = 1'b0;
            end
        end
        dval[d] = 1'b0;
        n = 0;
        while (done_n[d] == 0 && n < L * 4 + 200) begin @(negedge clk); n++; end
        tests++;
        if (done_n[d] == 0) begin
            fails++;
            $display("FAIL done_timeout dut%0d: no done pulse, required 1", d);
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic int stream_errs(input int d);
        int e;
        e = 0;
        for (int i = 0; i < len_of(d); i++) begin
            logic [7:0] b;
            b = host[d][i / 8];
            if (obs[d][i] != b[i % 8]) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        logic [35:0] got;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got = '0;
        for (int d = 0; d < 3; d++)
            got = {got[23:0], rdy[d], cen[d], bso[d], busy_v[d], done_v[d], rbv[d], rbd[d][5:0]} | {24'd0, 4'd0, rbd[d][7:6], 6'd0};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", got);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_bytes;
        int nb;
        host[0][0] = 8'hA5; host[0][1] = 8'h06;
        gapv[0][0] = 0;     gapv[0][1] = 0;
        nb = 2;
        run_load(0, 1'b0);
        tests++;
        if (stream_errs(0) != 0) begin
            fails++;
            $display("FAIL held_stream: %0d bit errors, required 0", stream_errs(0));
        end
        tests++;
        if (hi_n[0] != 11) begin fails++; $display("FAIL held_cen_count: got %0d, required 11", hi_n[0]); end
        tests++;
        if (gaps_sum[0] != 0) begin fails++; $display("FAIL held_no_gap: got %0d low cycles, required 0", gaps_sum[0]); end
        tests++;
        if (done_n[0] != 1) begin fails++; $display("FAIL held_done_pulses: got %0d, required 1", done_n[0]); end
        tests++;
        if (rdy_n[0] != nb) begin fails++; $display("FAIL held_ready_count: got %0d, required %0d", rdy_n[0], nb); end
        tests++;
        if (rb_n[0] != RB_ON * nb) begin fails++; $display("FAIL held_rb_count: got %0d, required %0d", rb_n[0], RB_ON * nb); end
        tests++;
        if ({busy_v[0], rdy[0], cen[0]} !== 3'b000) begin
            fails++;
            $display("FAIL held_idle_after: busy/ready/cen=%b, required 000", {busy_v[0], rdy[0], cen[0]});
        end
    endtask

    task automatic test_byte_gap;
        host[1][0] = 8'($urandom); host[1][1] = 8'($urandom);
        gapv[1][0] = 0;            gapv[1][1] = 5;
        run_load(1, 1'b0);
        tests++;
        if (stream_errs(1) != 0) begin fails++; $display("FAIL gap_stream: %0d bit errors, required 0", stream_errs(1)); end
        tests++;
        if (hi_n[1] != 16) begin fails++; $display("FAIL gap_cen_count: got %0d, required 16", hi_n[1]); end
        tests++;
        if (gaps_sum[1] != 5) begin fails++; $display("FAIL gap_low_cycles: got %0d, required 5", gaps_sum[1]); end
        tests++;
        if (done_n[1] != 1) begin fails++; $display("FAIL gap_done_pulses: got %0d, required 1", done_n[1]); end
    endtask

    task automatic test_ignored_inputs;
        clear_mon(1);
        @(negedge clk);
        din_v[1] = 8'h3C; dval[1] = 1'b1;
        repeat (5) @(negedge clk);
        dval[1] = 1'b0;
        tests++;
        if (rdy_n[1] != 0 || hi_n[1] != 0 || busy_v[1] !== 1'b0) begin
            fails++;
            $display("FAIL idle_valid_ignored: ready=%0d cen=%0d busy=%b, required 0 0 0", rdy_n[1], hi_n[1], busy_v[1]);
        end
        host[1][0] = 8'($urandom); host[1][1] = 8'($urandom);
        gapv[1][1] = 0;
        run_load(1, 1'b1);
        tests++;
        if (hi_n[1] != 16) begin fails++; $display("FAIL start_in_shift_count: got %0d, required 16", hi_n[1]); end
        tests++;
        if (stream_errs(1) != 0) begin fails++; $display("FAIL start_in_shift_stream: %0d bit errors, required 0", stream_errs(1)); end
        tests++;
        if (done_n[1] != 1) begin fails++; $display("FAIL start_in_shift_done: got %0d, required 1", done_n[1]); end
    endtask

    task automatic test_reset_mid_shift;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        din_v[0] = 8'hFF; dval[0] = 1'b1;
        @(negedge clk); dval[0] = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (cen[0] !== 1'b1) begin fails++; $display("FAIL mid_shift_active: config_en=%b, required 1", cen[0]); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({cen[0], bso[0], busy_v[0], rdy[0]} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid_shift: cen/bs/busy/ready=%b, required 0000", {cen[0], bso[0], busy_v[0], rdy[0]});
        end
        @(negedge clk); reset = 1'b0;
        host[0][0] = 8'($urandom); host[0][1] = 8'($urandom);
        gapv[0][1] = $urandom_range(0, 2);
        run_load(0, 1'b0);
        tests++;
        if (hi_n[0] != 11 || stream_errs(0) != 0) begin
            fails++;
            $display("FAIL fresh_after_reset: cen=%0d errs=%0d, required 11 0", hi_n[0], stream_errs(0));
        end
    endtask

    task automatic test_full_chain;
        logic [7:0] p [MAXB];
        int exp_gap, e;
        for (int pass = 0; pass < 2; pass++) begin
            exp_gap = 0;
            for (int k = 0; k < MAXB; k++) begin
                if (pass == 0) p[k] = host[2][k];
                host[2][k] = 8'($urandom);
                gapv[2][k] = $urandom_range(0, 3);
                if (k > 0) exp_gap += gapv[2][k];
            end
            run_load(2, 1'b0);
            tests++;
            if (stream_errs(2) != 0) begin fails++; $display("FAIL full_stream pass%0d: %0d bit errors, required 0", pass, stream_errs(2)); end
            tests++;
            if (hi_n[2] != 523) begin fails++; $display("FAIL full_cen_count pass%0d: got %0d, required 523", pass, hi_n[2]); end
            tests++;
            if (gaps_sum[2] != exp_gap) begin fails++; $display("FAIL full_gap_cycles pass%0d: got %0d, required %0d", pass, gaps_sum[2], exp_gap); end
            tests++;
            if (done_n[2] != 1) begin fails++; $display("FAIL full_done pass%0d: got %0d, required 1", pass, done_n[2]); end
            tests++;
            if (rb_n[2] != RB_ON * MAXB) begin fails++; $display("FAIL full_rb_count pass%0d: got %0d, required %0d", pass, rb_n[2], RB_ON * MAXB); end
`ifdef RETOSPECT_BS_READBACK_EN
            if (pass == 1) begin
                e = 0;
                for (int k = 0; k < MAXB; k++)
                    if (rb_got[2][k] !== ((k == MAXB - 1) ? (p[k] & last_mask(2)) : p[k])) e++;
                tests++;
                if (e != 0) begin fails++; $display("FAIL readback_previous: %0d bytes differ, required 0", e); end
            end
`endif
            e = 0;
            for (int i = 0; i < 523; i++) begin
                logic [7:0] b;
                b = host[2][i / 8];
                if (chain[2][i] != b[i % 8]) e++;
            end
            tests++;
            if (e != 0) begin fails++; $display("FAIL chain_image pass%0d: %0d bits wrong, required 0", pass, e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; din_v[d] = 8'h00; dval[d] = 1'b0;
            clear_mon(d);
        end
        test_reset;
        test_held_bytes;
        test_byte_gap;
        test_ignored_inputs;
        test_reset_mid_shift;
        test_full_chain;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/retospect_bs_loader.md
Name: retospect_bs_loader

Overview:
- Host-side writer for the neurochip configuration shift chain.
- Accepts config bytes over a valid/ready byte stream and serialises them onto the chain's bs_in, holding config_en high for exactly CHAIN_LEN shift cycles.
- Sits between the host/pin interface and the chain head (clockbox first, then the CNB array); the chain tail returns on bs_ret.

Parameters:
- CHAIN_LEN, 523, total chain bits (6 clock registers x 8 bits + 25 CNBs x 19 bits); must be >= 1.
- CNT_W, 10, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless IDLE
- din  in  8  config byte, LSB shifted first
- din_valid  in  1  din holds a valid byte
- din_ready  out  1  loader accepts din this cycle
- config_en  out  1  chain shift enable (registered)
- bs_out  out  1  serial data to chain bs_in (registered)
- bs_ret  in  1  serial data from chain tail bs_out
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle pulse when all CHAIN_LEN bits have been shifted
- rb_data  out  8  readback byte (feature only, else 0)
- rb_valid  out  1  readback byte strobe (feature only, else 0)

Behaviour:
- Reset: all outputs 0; state IDLE; counters and shift register cleared. Reset mid-load drops config_en immediately. A partial chain load is not resumed.
- Byte count NB = ceil(CHAIN_LEN/8). The final byte uses only its low (CHAIN_LEN mod 8) bits, or all 8 bits if the mod is 0. Its unused upper bits are discarded.
- FSM IDLE: din_ready=0. start=1 moves to WAIT and clears bit_cnt.
- FSM WAIT: din_ready=1. On din_valid&din_ready, load sr<=din and byte_bit<=0, then go to SHIFT.
- FSM SHIFT: each cycle, config_en=1 and bs_out=sr[0] (both registered, so they present the bit on the next edge). Then sr>>=1, byte_bit++, bit_cnt++.
  - bit_cnt reaching CHAIN_LEN goes to DONE.
  - byte_bit reaching 7 with more bits remaining: din_ready=1 in that cycle. If din_valid, the next byte loads with no gap and SHIFT continues. Otherwise go to WAIT, with config_en=0 during the wait.
- FSM DONE: done=1 for one cycle, config_en=0, then IDLE.
- Chain register bits hold while config_en=0, so a gap between bytes is harmless.
- Total config_en-high cycles per load equals CHAIN_LEN exactly, regardless of gaps.
- First bit shifted (byte0 bit0) ends at the far end of the chain (last CNB clockDecaySelect[0]). The host orders bytes far-end-first.
- start during WAIT, SHIFT or DONE is ignored.
- din_valid outside din_ready is ignored; no data is lost, and the host holds din.
- busy = state is WAIT, SHIFT or DONE.

Optional Feature:
- Macro RETOSPECT_BS_READBACK_EN.
- Defined: on every cycle the chain shifts (config_en high at the edge), sample bs_ret (the chain's old tail bit) into rb_sr, MSB-in right shift.
  - Every 8 samples: rb_data<=rb_sr and rb_valid=1 for one cycle.
  - Final partial byte: right-aligned (shifted down by 8-(CHAIN_LEN mod 8)), issued with rb_valid in the DONE cycle.
  - Exactly NB rb_valid pulses per load. Readback returns the previous configuration in the same bit order as it was loaded.
- Undefined: rb_data=0 and rb_valid=0 constantly; no readback logic is synthesised.

Test Plan:
- CHAIN_LEN=11, start, bytes 0xA5 then 0x06, din_valid held -> config_en high for 11 cycles with no gap; bs_out sequence 1,0,1,0,0,1,0,1,0,1,1; done pulses once; din_ready high exactly twice.
- CHAIN_LEN=16, first byte given, second byte delayed 5 cycles -> config_en low for the 5 wait cycles; total high count is 16; done pulses after the 16th shift.
- Reset asserted mid-SHIFT -> config_en, bs_out, busy and din_ready go 0 immediately; the next start begins a fresh load from bit 0.
- start pulsed during SHIFT, and din_valid asserted in IDLE -> no effect; bit count unaffected; din_ready stays 0 in IDLE.
- With RETOSPECT_BS_READBACK_EN, CHAIN_LEN=523 and a chain model: load pattern P then pattern Q -> the second load's 66 rb bytes equal P (last byte masked to 3 bits); rb_valid pulses 66 times.
- Full 25-CNB chip model, load CHAIN_LEN=523 -> the clockbox clock_max registers and every CNB's weight fields match the intended values after done.
